// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: each word is steered by its select bit into
// one of two small per-channel FIFOs, with per-channel accepted-word counters for debug.

module Demux2StreamFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] OCC_ONE  = (PW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_occ;
    logic             r_full;
    logic             r_valid;

    logic             w_push;
    logic             w_pop;
    logic [PW:0]      w_occ_next;

    // A full FIFO refuses the push even when it is popping in the same cycle.
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & r_valid;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + OCC_ONE;
        end else if (w_pop && !w_push) begin
            w_occ_next = r_occ - OCC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_occ   <= w_occ_next;
            r_full  <= (w_occ_next == OCC_FULL);
            r_valid <= (w_occ_next != '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = r_valid;
    assign o_full  = r_full;
endmodule

module demux2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic             w_full0;
    logic             w_full1;
    logic             w_accept;
    logic             w_push0;
    logic             w_push1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Ready depends only on the select and registered full flags, never on the consumers.
    assign in_ready = in_sel ? ~w_full1 : ~w_full0;
    assign w_accept = in_valid & in_ready;
    assign w_push0  = w_accept & ~in_sel;
    assign w_push1  = w_accept & in_sel;

    Demux2StreamFifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push0),
        .i_data  (in_data),
        .i_pop   (out0_ready),
        .o_data  (out0_data),
        .o_valid (out0_valid),
        .o_full  (w_full0)
    );

    Demux2StreamFifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push1),
        .i_data  (in_data),
        .i_pop   (out1_ready),
        .o_data  (out1_data),
        .o_valid (out1_valid),
        .o_full  (w_full1)
    );

    // Debug counters wrap freely; they count accepted words, not delivered ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_push1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: directed scenarios plus a randomized run,
// all compared against a queue-based model of the two channels.

module tb_demux2_stream;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [CNT_W-1:0] mCnt0;
    logic [CNT_W-1:0] mCnt1;

    int nCompared;
    int nMismatched;

    demux2_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observable state: {in_ready, v0, d0, v1, d1, cnt0, cnt1}.
    function automatic logic [50:0] expState();
        logic       rdy;
        logic [7:0] h0;
        logic [7:0] h1;
        rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        h0  = (q0.size() != 0) ? q0[0] : 8'h00;
        h1  = (q1.size() != 0) ? q1[0] : 8'h00;
        return {rdy, q0.size() != 0, h0, q1.size() != 0, h1, mCnt0, mCnt1};
    endfunction

    // Data is don't-care while the model says a channel is empty.
    function automatic logic [50:0] obsState();
        logic [7:0] d0;
        logic [7:0] d1;
        d0 = (q0.size() != 0) ? out0_data : 8'h00;
        d1 = (q1.size() != 0) ? out1_data : 8'h00;
        return {in_ready, out0_valid, d0, out1_valid, d1, cnt0, cnt1};
    endfunction

    task automatic modelReset();
        q0.delete();
        q1.delete();
        mCnt0 = '0;
        mCnt1 = '0;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Advance one clock; the model decides transfers from pre-edge occupancy.
    task automatic tick();
        logic acc;
        logic pop0;
        logic pop1;
        acc  = in_valid && (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
        pop0 = out0_ready && (q0.size() != 0);
        pop1 = out1_ready && (q1.size() != 0);
        @(posedge clk);
        #1;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (acc) begin
            if (in_sel) begin
                q1.push_back(in_data);
                mCnt1 = mCnt1 + 1'b1;
            end else begin
                q0.push_back(in_data);
                mCnt0 = mCnt0 + 1'b1;
            end
        end
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        modelReset();
        #12;
        nCompared++;
        if ({out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1} !== 50'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_initial: got %h expected 0",
                     {out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1});
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
        #1;
        tick();
        drive(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (obsState() !== expState()) begin
            nMismatched++;
            $display("[TB] FAIL reset_prefill: got %h expected %h", obsState(), expState());
        end
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        nCompared++;
        if ({out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1} !== 50'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_async: got %h expected 0",
                     {out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1});
        end
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            drive(1'b0, s[0], 8'h00, 1'b0, 1'b0);
            #1;
            nCompared++;
            if (in_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL reset_ready_sel%0d: got %b expected 1", s, in_ready);
            end
        end
        tick();
    endtask

    task automatic test_alternating();
        logic [7:0] words [3];
        logic       sels [3];
        words = '{8'h10, 8'h21, 8'h32};
        sels  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sels[i], words[i], 1'b1, 1'b1);
            #1;
            nCompared++;
            if (obsState() !== expState()) begin
                nMismatched++;
                $display("[TB] FAIL alt_pre%0d: got %h expected %h", i, obsState(), expState());
            end
            tick();
            nCompared++;
            if ((sels[i] ? {out1_valid, out1_data} : {out0_valid, out0_data}) !== {1'b1, words[i]}) begin
                nMismatched++;
                $display("[TB] FAIL alt_deliver%0d: got %h expected %h", i,
                         sels[i] ? {out1_valid, out1_data} : {out0_valid, out0_data}, {1'b1, words[i]});
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        nCompared++;
        if ({cnt0, cnt1} !== {16'd2, 16'd1}) begin
            nMismatched++;
            $display("[TB] FAIL alt_counts: got %h expected %h", {cnt0, cnt1}, {16'd2, 16'd1});
        end
        drain();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
        #1;
        nCompared++;
        if (in_ready !== 1'b0 || obsState() !== expState()) begin
            nMismatched++;
            $display("[TB] FAIL bp_full: got %h expected %h", obsState(), expState());
        end
        tick();
        drive(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
        #1;
        nCompared++;
        if (in_ready !== 1'b0 || out0_data !== 8'h01) begin
            nMismatched++;
            $display("[TB] FAIL bp_pop_cycle: got rdy=%b d=%h expected rdy=0 d=01", in_ready, out0_data);
        end
        tick();
        drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
        #1;
        nCompared++;
        if (in_ready !== 1'b1 || obsState() !== expState()) begin
            nMismatched++;
            $display("[TB] FAIL bp_turnaround: got %h expected %h", obsState(), expState());
        end
        tick();
        for (int i = 2; i <= 3; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            #1;
            nCompared++;
            if ({out0_valid, out0_data} !== {1'b1, 8'(i)}) begin
                nMismatched++;
                $display("[TB] FAIL bp_order%0d: got %h expected %h", i, {out0_valid, out0_data}, {1'b1, 8'(i)});
            end
            tick();
        end
        drain();
    endtask

    task automatic test_independence();
        drive(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL indep_ready: got %b expected 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        nCompared++;
        if ({out1_valid, out1_data, out0_valid, out0_data} !== {1'b1, 8'h55, 1'b1, 8'hC1}
            || obsState() !== expState()) begin
            nMismatched++;
            $display("[TB] FAIL indep_deliver: got %h expected %h", obsState(), expState());
        end
        drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        #1;
        nCompared++;
        if (obsState() !== expState()) begin
            nMismatched++;
            $display("[TB] FAIL b2b_pre: got %h expected %h", obsState(), expState());
        end
        tick();
        drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        #1;
        nCompared++;
        if ({out1_valid, out1_data, in_ready} !== {1'b1, 8'h77, 1'b1} || q1.size() != 1) begin
            nMismatched++;
            $display("[TB] FAIL b2b_head: got %h expected %h", {out1_valid, out1_data, in_ready}, {1'b1, 8'h77, 1'b1});
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
            #1;
            nCompared++;
            if (obsState() !== expState()) begin
                nMismatched++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, obsState(), expState());
            end
            tick();
        end
        drain();
    endtask

    task automatic test_counter_wrap();
        logic [CNT_W-1:0] keep1;
        rst_n = 1'b0;
        modelReset();
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        nCompared++;
        if (cnt0 !== mCnt0 || cnt0 !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL wrap_preload: got %h expected ffff", cnt0);
        end
        keep1 = mCnt1;
        drive(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        nCompared++;
        if ({cnt0, cnt1} !== {16'h0000, keep1}) begin
            nMismatched++;
            $display("[TB] FAIL wrap_rollover: got %h expected %h", {cnt0, cnt1}, {16'h0000, keep1});
        end
        drain();
        nCompared++;
        if (q0.size() != 0 || q1.size() != 0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL final_drain: got v0=%b v1=%b expected both 0", out0_valid, out1_valid);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b0;
        modelReset();
        test_reset();
        test_alternating();
        test_backpressure();
        test_independence();
        test_back_to_back();
        test_random();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 stream demultiplexer with valid/ready handshaking and a small FIFO per output channel. It sits directly downstream of the word source and replaces the bare combinational 1-to-2 demux wherever the two consumers can stall independently. A word is steered by its select bit into channel 0 or channel 1 and held until that consumer accepts it. Per-channel accepted-word counters are provided for debug.

## Interface

- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 2, entries per channel FIFO (power of 2, ≥2).
- CNT_W, 16, width of per-channel word counters.

- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  destination: 0 → channel 0, 1 → channel 1; qualified by in_valid.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  channel 0 head word.
- out0_valid  output  1  channel 0 FIFO non-empty.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  WIDTH  channel 1 head word.
- out1_valid  output  1  channel 1 FIFO non-empty.
- out1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  words accepted into channel 0 since reset.
- cnt1  output  CNT_W  words accepted into channel 1 since reset.

## Operation

- Reset (rst_n low, any time, asynchronous): both FIFOs emptied (read/write pointers and occupancy 0), out0_valid = out1_valid = 0, cnt0 = cnt1 = 0, out*_data = 0. In-flight words are discarded; no partial transfer survives.
- in_ready = ~full[in_sel] (combinational on in_sel and registered full flags only; no path from out*_ready to in_ready).
- Accept: in_valid & in_ready at rising edge → in_data written to FIFO[in_sel], that channel's occupancy +1, cnt[in_sel] +1.
- Pop: outN_valid & outN_ready at rising edge → FIFO[N] head removed, occupancy −1.
- Push and pop on the same channel in the same cycle: occupancy unchanged, both take effect. Only possible when not full (full blocks the push regardless of the concurrent pop).
- Push to one channel while the other pops: independent.
- Channels never reorder within themselves; no ordering guarantee across channels.
- in_valid low: in_sel and in_data ignored; in_ready still reflects ~full[in_sel].
- in_valid high while in_ready low: nothing written, counters unchanged; source holds word (standard valid/ready).
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Occupancy: log2(DEPTH)+1 bits; full = (occ == DEPTH), empty = (occ == 0).
- Counters wrap modulo 2^CNT_W (0xFFFF + 1 → 0x0000 for default), no saturation.
- outN_data = FIFO[N] head entry; value when outN_valid = 0 is don't-care except 0 after reset.

## Timing

- Latency: word accepted at edge k is visible on outN_data with outN_valid = 1 after edge k (cycle k+1); zero bubble when FIFO empty.
- Throughput: one accepted word per cycle, provided the selected channel is not full.
- Full channel: in_ready for that select is low until the cycle after a pop brings occupancy below DEPTH (one-cycle turnaround, by design).
- cnt0/cnt1 update on the same edge as the write; registered outputs.
- outN_valid, full flags, counters all registered; in_ready is the only combinational output.

## Test plan

- Reset mid-stream: fill channel 0 with 0xA1, 0xA2, assert rst_n low between edges → out0_valid, out1_valid, cnt0, cnt1 go 0 immediately (before next edge); after release in_ready = 1 for both selects.
- Alternating routing: send 0x10(sel0), 0x21(sel1), 0x32(sel0) with both readies high → out0 shows 0x10 then 0x32, out1 shows 0x21, each one cycle after acceptance; cnt0 = 2, cnt1 = 1.
- Backpressure/full: out0_ready = 0, send 0x01, 0x02, 0x03 on sel0 → first two accepted, in_ready low on the third; raise out0_ready one cycle → 0x01 pops, in_ready returns high the next cycle, 0x03 accepted; order 0x01, 0x02, 0x03 preserved.
- Independence: channel 0 full and stalled, present sel1 word 0x55 → in_ready = 1, 0x55 delivered on out1; channel 0 contents untouched.
- Simultaneous push/pop: channel 1 holding one word, out1_ready = 1 and push 0x77 to sel1 same cycle → occupancy stays 1, next head is 0x77.
- Counter wrap: preload by sending 65 535 words on sel0, then one more → cnt0 goes 0xFFFF → 0x0000, cnt1 unchanged.
